// File: rtl/dmac_pkg.sv
// Shared AHB-Lite encodings and channel state names for the DMA channel sequencer.
package dmac_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HBURST_INCR = 3'b001;

    typedef enum logic [2:0] {
        CH_IDLE     = 3'd0,
        CH_RD       = 3'd1,
        CH_RD_DRAIN = 3'd2,
        CH_WR       = 3'd3,
        CH_WR_DRAIN = 3'd4,
        CH_DONE     = 3'd5,
        CH_ERR      = 3'd6
    } chan_state_t;

endpackage

// File: rtl/dmac_addr_gen.sv
// Beat-address pointer with load/increment and a flag marking the start of a 1 KB page.
module dmac_addr_gen #(
    parameter int ADDR_W     = 32,
    parameter int BEAT_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] ptr,
    output logic              at_bound
);

    // Pointer register; wraps naturally modulo 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + ADDR_W'(BEAT_BYTES);
        end
    end

    // A beat landing on a 1 KB page start has crossed the boundary and must restart the burst.
    assign at_bound = (ptr[9:0] == 10'd0);

endmodule

// File: rtl/dmac_chan_seq.sv
// DMA channel sequencer: alternating AHB-Lite INCR read/write bursts through the channel FIFO.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for cfg_start
// RD          | issuing read addresses from src_ptr (waits for empty FIFO)
// RD_DRAIN    | waiting for the last read data phase
// WR          | issuing write addresses from dst_ptr
// WR_DRAIN    | waiting for the last write data phase, then update remain
// DONE        | transfer complete, irq raised
// ERR         | bus error seen, err/irq raised
module dmac_chan_seq #(
    parameter int ADDR_W     = 32,
    parameter int SIZE_W     = 16,
    parameter int BLEN_W     = 4,
    parameter int BEAT_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [SIZE_W-1:0] cfg_size,
    input  logic [BLEN_W-1:0] cfg_blen,
    input  logic              irq_clr,
    input  logic              HReady,
    input  logic [1:0]        HResp,
    output logic [ADDR_W-1:0] HAddr,
    output logic [1:0]        HTrans,
    output logic              HWrite,
    output logic [2:0]        HBurst,
    output logic [2:0]        HSize,
    output logic              fifo_wr_en,
    output logic              fifo_rd_en,
    input  logic              fifo_empty,
    output logic              busy,
    output logic              irq,
    output logic              err
);
    import dmac_pkg::*;

    localparam int CW = BLEN_W + 1;

    localparam logic [2:0] S_IDLE     = CH_IDLE;
    localparam logic [2:0] S_RD       = CH_RD;
    localparam logic [2:0] S_RD_DRAIN = CH_RD_DRAIN;
    localparam logic [2:0] S_WR       = CH_WR;
    localparam logic [2:0] S_WR_DRAIN = CH_WR_DRAIN;
    localparam logic [2:0] S_DONE     = CH_DONE;
    localparam logic [2:0] S_ERR      = CH_ERR;

    logic [2:0]        state, state_nx;
    logic [CW-1:0]     acc_cnt, bl;
    logic [SIZE_W-1:0] remain, rem_after;
    logic              dphase, dwr, abort_r;
    logic              addr_phase, acc, last_acc, data_ok, data_err, start_ok, in_xfer;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic              src_bound, dst_bound, cur_bound, wr_side;
    htrans_t           ht;

    function automatic logic [CW-1:0] burst_len(input logic [SIZE_W-1:0] rem,
                                                input logic [BLEN_W-1:0] blen);
        logic [CW-1:0] lim;
        lim = {1'b0, blen} + CW'(1);
        if (rem < SIZE_W'(lim)) burst_len = rem[CW-1:0];
        else                    burst_len = lim;
    endfunction

    dmac_addr_gen #(.ADDR_W(ADDR_W), .BEAT_BYTES(BEAT_BYTES)) u_src (
        .clk(clk), .rst(rst), .load(start_ok), .inc(acc && state == S_RD),
        .load_val(cfg_src), .ptr(src_ptr), .at_bound(src_bound)
    );

    dmac_addr_gen #(.ADDR_W(ADDR_W), .BEAT_BYTES(BEAT_BYTES)) u_dst (
        .clk(clk), .rst(rst), .load(start_ok), .inc(acc && state == S_WR),
        .load_val(cfg_dst), .ptr(dst_ptr), .at_bound(dst_bound)
    );

    assign start_ok  = (state == S_IDLE) && cfg_start;
    assign wr_side   = (state == S_WR) || (state == S_WR_DRAIN);
    assign cur_bound = wr_side ? dst_bound : src_bound;
    assign in_xfer   = (state == S_RD) || (state == S_RD_DRAIN) ||
                       (state == S_WR) || (state == S_WR_DRAIN);

    // The FIFO must be empty before a read burst starts so it can hold the whole burst.
    assign addr_phase = !abort_r &&
                        (((state == S_RD) && ((acc_cnt != '0) || fifo_empty)) || (state == S_WR));
    assign acc        = addr_phase && HReady;
    assign last_acc   = acc && (acc_cnt == bl - CW'(1));
    assign data_ok    = dphase && HReady && (HResp == HRESP_OKAY);
    assign data_err   = dphase && (HResp == HRESP_ERROR);
    assign rem_after  = remain - SIZE_W'(bl);

    // Address-phase encoding: NONSEQ on burst start or 1 KB page restart.
    always_comb begin
        ht = HT_IDLE;
        if (addr_phase) begin
            ht = ((acc_cnt == '0) || cur_bound) ? HT_NONSEQ : HT_SEQ;
        end
    end

    // Next-state logic; error and abort override the normal burst flow.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (cfg_start) state_nx = (cfg_size == '0) ? S_DONE : S_RD;
            S_RD:       if (last_acc) state_nx = S_RD_DRAIN;
            S_RD_DRAIN: if (data_ok) state_nx = S_WR;
            S_WR:       if (last_acc) state_nx = S_WR_DRAIN;
            S_WR_DRAIN: if (data_ok) state_nx = (rem_after == '0) ? S_DONE : S_RD;
            S_DONE:     state_nx = S_IDLE;
            S_ERR:      state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
        if (in_xfer) begin
            if (data_err) begin
                state_nx = S_ERR;
            end else if (abort_r && (!dphase || data_ok)) begin
                state_nx = S_IDLE;
            end
        end
    end

    // State, beat counters, data-phase tracking and sticky status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            acc_cnt <= '0;
            bl      <= '0;
            remain  <= '0;
            dphase  <= 1'b0;
            dwr     <= 1'b0;
            abort_r <= 1'b0;
            irq     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) acc_cnt <= '0;
            else if (acc)          acc_cnt <= acc_cnt + CW'(1);
            if (data_err)    dphase <= 1'b0;
            else if (HReady) dphase <= addr_phase;
            if (acc) dwr <= (state == S_WR);
            abort_r <= (state_nx != S_IDLE) && (abort_r || (cfg_abort && state != S_IDLE));
            if (start_ok) begin
                remain <= cfg_size;
                bl     <= burst_len(cfg_size, cfg_blen);
            end else if ((state == S_WR_DRAIN) && data_ok) begin
                remain <= rem_after;
                bl     <= burst_len(rem_after, cfg_blen);
            end
            if ((state_nx == S_DONE) || (state_nx == S_ERR)) irq <= 1'b1;
            else if (irq_clr)                                irq <= 1'b0;
            if (state_nx == S_ERR) err <= 1'b1;
            else if (irq_clr)      err <= 1'b0;
        end
    end

    assign HTrans     = ht;
    assign HAddr      = wr_side ? dst_ptr : src_ptr;
    assign HWrite     = wr_side;
    assign HBurst     = HBURST_INCR;
    assign HSize      = 3'($clog2(BEAT_BYTES));
    assign fifo_wr_en = data_ok && !dwr;
    assign fifo_rd_en = data_ok && dwr;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_dmac_chan_seq.sv
// Directed bench for dmac_chan_seq: cycle-numbered scenarios with hand-computed expectations.
module tb_dmac_chan_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_abort, irq_clr;
    logic [31:0] cfg_src, cfg_dst;
    logic [15:0] cfg_size;
    logic [3:0]  cfg_blen;
    logic        HReady;
    logic [1:0]  HResp;
    logic [31:0] HAddr;
    logic [1:0]  HTrans;
    logic        HWrite;
    logic [2:0]  HBurst, HSize;
    logic        fifo_wr_en, fifo_rd_en, fifo_empty;
    logic        busy, irq, err;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_id = 0;
    int cur_cyc = 0;

    logic [31:0] bnd_addr [4] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
    logic [1:0]  bnd_tr   [4] = '{2'b10, 2'b11, 2'b10, 2'b11};

    dmac_chan_seq #(.ADDR_W(32), .SIZE_W(16), .BLEN_W(4), .BEAT_BYTES(4)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_size(cfg_size), .cfg_blen(cfg_blen),
        .irq_clr(irq_clr), .HReady(HReady), .HResp(HResp), .HAddr(HAddr),
        .HTrans(HTrans), .HWrite(HWrite), .HBurst(HBurst), .HSize(HSize),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
        .busy(busy), .irq(irq), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL s%0d c%0d %s: got 0x%0h want 0x%0h", cur_id, cur_cyc, tag, obs, exp);
        end
    endtask

    task automatic run_scn(input int id, input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] size, input logic [3:0] blen, input int ncyc);
        int n_wr, n_rd, irq_at;
        n_wr = 0; n_rd = 0; irq_at = -1;
        cur_id = id; cur_cyc = -1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        cfg_src = src; cfg_dst = dst; cfg_size = size; cfg_blen = blen;
        cfg_start = 1'b1;
        cur_cyc = 0;
        @(posedge clk); #1;
        for (int c = 1; c <= ncyc; c++) begin
            cur_cyc = c;
            cfg_start = 1'b0; cfg_abort = 1'b0; irq_clr = 1'b0; rst = 1'b0;
            HReady = 1'b1; HResp = 2'b00; fifo_empty = 1'b1;
            case (id)
                1: if (c == 22) irq_clr = 1'b1;
                4: begin
                    if (c == 3) HResp = 2'b01;
                    if (c == 6) irq_clr = 1'b1;
                end
                5: begin
                    if (c >= 7 && c <= 9) HReady = 1'b0;
                    if (c == 7) cfg_abort = 1'b1;
                end
                6: if (c == 1) begin cfg_start = 1'b1; cfg_size = 16'd8; end
                7: if (c == 1) fifo_empty = 1'b0;
                8: if (c == 3) rst = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            n_wr += int'(fifo_wr_en);
            n_rd += int'(fifo_rd_en);
            if (irq && irq_at < 0) irq_at = c;
            case (id)
                1: begin
                    if (c == 1) begin chk("htrans", HTrans, 2'b10); chk("haddr", HAddr, 32'h100); chk("hwrite", HWrite, 0); end
                    if (c == 2) begin chk("htrans", HTrans, 2'b11); chk("wr_en", fifo_wr_en, 1); end
                    if (c == 4) begin chk("htrans", HTrans, 2'b11); chk("haddr", HAddr, 32'h10C); end
                    if (c == 5) begin chk("htrans", HTrans, 2'b00); chk("wr_en", fifo_wr_en, 1); end
                    if (c == 6) begin chk("htrans", HTrans, 2'b10); chk("hwrite", HWrite, 1); chk("haddr", HAddr, 32'h200); end
                    if (c == 7) chk("rd_en", fifo_rd_en, 1);
                    if (c == 11) begin chk("htrans", HTrans, 2'b10); chk("haddr", HAddr, 32'h110); chk("hwrite", HWrite, 0); end
                    if (c == 21) chk("busy", busy, 1);
                    if (c == 22) chk("busy", busy, 0);
                    if (c == 23) chk("irq_clr", irq, 0);
                end
                2: begin
                    if (c == 11) begin chk("htrans", HTrans, 2'b10); chk("haddr", HAddr, 32'h1010); end
                    if (c == 12) begin chk("htrans", HTrans, 2'b00); chk("wr_en", fifo_wr_en, 1); end
                    if (c == 13) begin chk("htrans", HTrans, 2'b10); chk("haddr", HAddr, 32'h2010); chk("hwrite", HWrite, 1); end
                    if (c == 14) begin chk("rd_en", fifo_rd_en, 1); chk("irq", irq, 0); end
                end
                3: begin
                    if (c >= 1 && c <= 4) begin
                        chk("bnd_htrans", HTrans, bnd_tr[c-1]);
                        chk("bnd_haddr", HAddr, bnd_addr[c-1]);
                    end
                    if (c == 8) begin chk("htrans", HTrans, 2'b11); chk("haddr", HAddr, 32'h808); end
                end
                4: begin
                    if (c == 2) chk("wr_en", fifo_wr_en, 1);
                    if (c == 3) chk("wr_en_err", fifo_wr_en, 0);
                    if (c == 4) begin chk("htrans", HTrans, 2'b00); chk("err", err, 1); chk("irq", irq, 1); chk("busy", busy, 1); end
                    if (c == 5) begin chk("busy", busy, 0); chk("err", err, 1); end
                    if (c == 7) begin chk("err_clr", err, 0); chk("irq_clr", irq, 0); end
                end
                5: begin
                    if (c == 7) begin chk("htrans", HTrans, 2'b11); chk("haddr", HAddr, 32'h204); end
                    if (c == 8) begin chk("htrans", HTrans, 2'b00); chk("haddr", HAddr, 32'h204); end
                    if (c == 9) begin chk("haddr", HAddr, 32'h204); chk("rd_en", fifo_rd_en, 0); end
                    if (c == 10) begin chk("rd_en", fifo_rd_en, 1); chk("htrans", HTrans, 2'b00); end
                    if (c == 11) begin chk("busy", busy, 0); chk("irq", irq, 0); end
                    if (c == 13) chk("htrans", HTrans, 2'b00);
                end
                6: begin
                    if (c == 1) begin chk("busy", busy, 1); chk("htrans", HTrans, 2'b00); end
                    if (c == 2) begin chk("irq", irq, 1); chk("busy", busy, 0); end
                    if (c == 3) begin chk("busy", busy, 0); chk("htrans", HTrans, 2'b00); end
                end
                7: begin
                    if (c == 1) begin chk("htrans_nempty", HTrans, 2'b00); chk("busy", busy, 1); end
                    if (c == 2) begin chk("htrans", HTrans, 2'b10); chk("haddr", HAddr, 32'h40); end
                    if (c == 3) begin chk("htrans", HTrans, 2'b00); chk("wr_en", fifo_wr_en, 1); end
                    if (c == 4) begin chk("htrans", HTrans, 2'b10); chk("haddr", HAddr, 32'h80); chk("hwrite", HWrite, 1); end
                    if (c == 6) chk("irq", irq, 1);
                end
                8: begin
                    if (c == 3) chk("htrans", HTrans, 2'b11);
                    if (c == 4) begin chk("busy", busy, 0); chk("htrans", HTrans, 2'b00); chk("haddr", HAddr, 0); end
                    if (c == 5) chk("irq", irq, 0);
                end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        cur_cyc = 99;
        case (id)
            1: begin chk("n_wr", n_wr, 8); chk("n_rd", n_rd, 8); chk("irq_at", irq_at, 21); end
            2: begin chk("n_wr", n_wr, 5); chk("n_rd", n_rd, 5); chk("irq_at", irq_at, 15); end
            3: begin chk("n_wr", n_wr, 4); chk("n_rd", n_rd, 4); chk("irq_at", irq_at, 11); end
            4: chk("n_wr", n_wr, 1);
            5: begin chk("n_wr", n_wr, 4); chk("n_rd", n_rd, 1); chk("irq_at", irq_at, -1); end
            6: begin chk("n_wr", n_wr, 0); chk("n_rd", n_rd, 0); end
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; irq_clr = 1'b0;
        cfg_src = '0; cfg_dst = '0; cfg_size = '0; cfg_blen = '0;
        HReady = 1'b1; HResp = 2'b00; fifo_empty = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_htrans", HTrans, 2'b00);
        chk("rst_haddr", HAddr, 0);
        chk("rst_hwrite", HWrite, 0);
        chk("rst_strobes", {fifo_wr_en, fifo_rd_en}, 0);
        chk("rst_status", {busy, irq, err}, 0);
        chk("hburst", HBurst, 3'b001);
        chk("hsize", HSize, 3'd2);

        run_scn(1, 32'h100,  32'h200,  16'd8, 4'd3, 24);
        run_scn(2, 32'h1000, 32'h2000, 16'd5, 4'd3, 17);
        run_scn(3, 32'h3F8,  32'h800,  16'd4, 4'd3, 13);
        run_scn(4, 32'h100,  32'h200,  16'd8, 4'd3, 8);
        run_scn(5, 32'h100,  32'h200,  16'd8, 4'd3, 14);
        run_scn(6, 32'h500,  32'h600,  16'd0, 4'd3, 4);
        run_scn(7, 32'h40,   32'h80,   16'd1, 4'd0, 7);
        run_scn(8, 32'h100,  32'h200,  16'd8, 4'd3, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
